// File: rtl/tx_link_control.sv
// Transmit link controller: streams preamble, payload read from the TX
// buffer RAM, and an appended reflected CRC-32 to the 4B5B encoder over a
// valid/ready byte handshake. Every output is driven straight from a flop.
module tx_link_control #(
  parameter int               n        = 11,
  parameter int               width    = 8,
  parameter int               PRE_LEN  = 2,
  parameter logic [width-1:0] PRE_BYTE = 8'h55
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_start,
  input  logic [n-1:0]     tx_len,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             buf_ren,
  output logic [n-1:0]     buf_raddr,
  input  logic [width-1:0] buf_rdata,
  output logic             enc_frame,
  output logic             enc_valid,
  output logic [width-1:0] enc_data,
  input  logic             enc_ready
);

  typedef enum logic [2:0] {IDLE, PRE, FETCH, WAIT, DATA, CRC, DONE} state_t;

  localparam logic [3:0]   PRE_LAST = 4'(PRE_LEN - 1);
  localparam logic [n-1:0] ONE      = {{(n-1){1'b0}}, 1'b1};

  state_t         state, state_nxt;
  logic [n-1:0]   len_r, len_nxt;
  logic [n-1:0]   idx, idx_nxt;
  logic [31:0]    crc, crc_nxt;
  logic [3:0]     pre_cnt, pre_cnt_nxt;
  logic [1:0]     crc_cnt, crc_cnt_nxt;
  logic [31:0]    crc_tx;
  logic           xfer;

  logic             busy_d, done_d, ren_d, frame_d, valid_d;
  logic [n-1:0]     raddr_d;
  logic [width-1:0] data_d;

  // Reflected CRC-32 (poly 0xEDB88320) advanced by one full byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign xfer = enc_valid && enc_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; handshake stalls simply hold the current state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (tx_start) begin
          if (PRE_LEN != 0)    state_nxt = PRE;
          else if (tx_len != 0) state_nxt = FETCH;
          else                  state_nxt = CRC;
        end
      end
      PRE:   if (xfer && pre_cnt == PRE_LAST) state_nxt = (len_r != 0) ? FETCH : CRC;
      FETCH: state_nxt = WAIT;
      WAIT:  state_nxt = DATA;
      DATA:  if (xfer) state_nxt = (idx == len_r - ONE) ? CRC : FETCH;
      CRC:   if (xfer && crc_cnt == 2'd3) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values: length capture, payload index, CRC, byte counters.
  always_comb begin
    len_nxt     = len_r;
    idx_nxt     = idx;
    crc_nxt     = crc;
    pre_cnt_nxt = pre_cnt;
    crc_cnt_nxt = crc_cnt;
    case (state)
      IDLE: begin
        if (tx_start) begin
          len_nxt     = tx_len;
          idx_nxt     = '0;
          crc_nxt     = 32'hFFFFFFFF;
          pre_cnt_nxt = '0;
          crc_cnt_nxt = '0;
        end
      end
      PRE:  if (xfer) pre_cnt_nxt = pre_cnt + 4'd1;
      DATA: begin
        if (xfer) begin
          crc_nxt = crc32_byte(crc, enc_data);
          idx_nxt = idx + ONE;
        end
      end
      CRC:  if (xfer) crc_cnt_nxt = crc_cnt + 2'd1;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r   <= '0;
      idx     <= '0;
      crc     <= 32'hFFFFFFFF;
      pre_cnt <= '0;
      crc_cnt <= '0;
    end else begin
      len_r   <= len_nxt;
      idx     <= idx_nxt;
      crc     <= crc_nxt;
      pre_cnt <= pre_cnt_nxt;
      crc_cnt <= crc_cnt_nxt;
    end
  end

  // Output decode from the upcoming state so the flopped outputs line up
  // with the state they describe.
  always_comb begin
    busy_d  = (state_nxt != IDLE);
    done_d  = (state_nxt == DONE);
    ren_d   = (state_nxt == FETCH);
    frame_d = (state_nxt == PRE) || (state_nxt == FETCH) || (state_nxt == WAIT) ||
              (state_nxt == DATA) || (state_nxt == CRC);
    valid_d = (state_nxt == PRE) || (state_nxt == DATA) || (state_nxt == CRC);
    raddr_d = ren_d ? idx_nxt : buf_raddr;
    crc_tx  = ~crc_nxt;
    data_d  = enc_data;
    case (state_nxt)
      PRE:  data_d = PRE_BYTE;
      // Only the WAIT->DATA edge loads RAM data; a stalled DATA byte holds.
      DATA: if (state == WAIT) data_d = buf_rdata;
      CRC: begin
        case (crc_cnt_nxt)
          2'd0:    data_d = crc_tx[7:0];
          2'd1:    data_d = crc_tx[15:8];
          2'd2:    data_d = crc_tx[23:16];
          default: data_d = crc_tx[31:24];
        endcase
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      buf_ren   <= 1'b0;
      buf_raddr <= '0;
      enc_frame <= 1'b0;
      enc_valid <= 1'b0;
      enc_data  <= '0;
    end else begin
      tx_busy   <= busy_d;
      tx_done   <= done_d;
      buf_ren   <= ren_d;
      buf_raddr <= raddr_d;
      enc_frame <= frame_d;
      enc_valid <= valid_d;
      enc_data  <= data_d;
    end
  end

endmodule
